// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  localparam int WBYTES = 4;
endpackage

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - per-CPU instruction read channel to the memory controller
interface cache_control_if #(parameter int CPUS = 1);
  import cpu_types_pkg::*;
  logic [CPUS-1:0] iREN;
  logic [CPUS-1:0] iwait;
  word_t           iaddr [CPUS];
  word_t           iload [CPUS];

  modport caches (output iREN, output iaddr, input iwait, input iload);
endinterface

// File: rtl/datapath_cache_if.sv
// rtl/datapath_cache_if.sv - fetch port between datapath and instruction cache
interface datapath_cache_if;
  import cpu_types_pkg::*;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport cache (input imemREN, input imemaddr, output ihit, output imemload);
endinterface

// File: rtl/icache_lru.sv
// rtl/icache_lru.sv - true-LRU age tracking per set
module icache_lru #(
  parameter int SETS = 8,
  parameter int WAYS = 2,
  localparam int IDXW = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [IDXW-1:0] i_set,
  input  logic            i_touch,
  input  logic [WAYW-1:0] i_way,
  output logic [WAYW-1:0] o_lru_way
);

  generate
    if (WAYS == 1) begin : g_one
      logic w_unused;
      assign w_unused  = &{1'b0, CLK, nRST, i_set, i_touch, i_way};
      assign o_lru_way = '0;
    end else begin : g_lru
      logic [WAYW-1:0] r_age [SETS][WAYS];
      logic [WAYW-1:0] w_best;

      // Equal ages (only possible after reset) count as younger, so order emerges from all-zero.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              r_age[s][w] <= '0;
        end else if (i_touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAYW'(w) == i_way)
              r_age[i_set][w] <= '0;
            else if (r_age[i_set][w] <= r_age[i_set][i_way])
              r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
          end
        end
      end

      always_comb begin
        o_lru_way = '0;
        w_best    = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (r_age[i_set][w] > w_best) begin
            w_best    = r_age[i_set][w];
            o_lru_way = WAYW'(w);
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with true-LRU and multi-word fills
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2,
  parameter int CPUID    = 0
) (
  input logic               CLK,
  input logic               nRST,
  datapath_cache_if.cache   dcif,
  cache_control_if.caches   ccif
);

  localparam int OFF  = $clog2(BLKWORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - 2 - OFF - IDX;
  localparam int OFFW = (OFF > 0) ? OFF : 1;
  localparam int IDXW = (IDX > 0) ? IDX : 1;
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam word_t BLKMASK = word_t'(BLKWORDS * WBYTES - 1);

  typedef enum logic {IDLE, FILL} icache_state_t;

  icache_state_t   r_state, w_next;
  logic            r_valid [SETS][WAYS];
  logic [TAGW-1:0] r_tag   [SETS][WAYS];
  word_t           r_data  [SETS][WAYS][BLKWORDS];
  logic [OFFW-1:0] r_k;
  word_t           r_base;
  logic [IDXW-1:0] r_fidx;
  logic [TAGW-1:0] r_ftag;
  logic [WAYW-1:0] r_victim;

  logic [29:0]     w_word;
  logic [OFFW-1:0] w_off;
  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_tag;
  logic            w_hit_any, w_inv_any, w_hit, w_ren, w_last, w_xfer, w_unused;
  logic [WAYW-1:0] w_hit_way, w_inv_way, w_lru_way, w_victim;
  logic [IDXW-1:0] w_lru_set;
  word_t           w_iaddr;

  assign w_word   = dcif.imemaddr[31:2];
  assign w_tag    = w_word[29:OFF+IDX];
  assign w_unused = &{1'b0, dcif.imemaddr[1:0]};

  generate
    if (OFF > 0) begin : g_off
      assign w_off = w_word[OFF-1:0];
    end else begin : g_no_off
      assign w_off = '0;
    end
    if (IDX > 0) begin : g_idx
      assign w_idx = w_word[OFF+IDX-1:OFF];
    end else begin : g_no_idx
      assign w_idx = '0;
    end
  endgenerate

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAYW'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_inv_any = 1'b1;
        w_inv_way = WAYW'(w);
      end
    end
  end

  assign w_victim = w_inv_any ? w_inv_way : w_lru_way;
  assign w_last   = (r_k == OFFW'(BLKWORDS - 1));
  assign w_xfer   = (r_state == FILL) && !ccif.iwait[CPUID];

  always_comb begin
    w_next  = r_state;
    w_ren   = 1'b0;
    w_iaddr = '0;
    w_hit   = 1'b0;
    case (r_state)
      IDLE: begin
        w_hit = dcif.imemREN && w_hit_any;
        if (dcif.imemREN && !w_hit_any) w_next = FILL;
      end
      FILL: begin
        w_ren   = 1'b1;
        w_iaddr = r_base | (word_t'(r_k) << 2);
        if (!ccif.iwait[CPUID] && w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_base   <= '0;
      r_fidx   <= '0;
      r_ftag   <= '0;
      r_victim <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_valid[s][w] <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == FILL) begin
        r_base   <= dcif.imemaddr & ~BLKMASK;
        r_fidx   <= w_idx;
        r_ftag   <= w_tag;
        r_victim <= w_victim;
        r_k      <= '0;
      end
      if (w_xfer) begin
        if (w_last) begin
          r_valid[r_fidx][r_victim] <= 1'b1;
          r_k <= '0;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  // Tags are qualified by valid and data by tag, so neither needs reset.
  always_ff @(posedge CLK) begin
    if (w_xfer) begin
      r_data[r_fidx][r_victim][r_k] <= ccif.iload[CPUID];
      if (w_last) r_tag[r_fidx][r_victim] <= r_ftag;
    end
  end

  assign w_lru_set = (r_state == FILL) ? r_fidx : w_idx;

  icache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_set     (w_lru_set),
    .i_touch   (w_hit || (w_xfer && w_last)),
    .i_way     ((r_state == FILL) ? r_victim : w_hit_way),
    .o_lru_way (w_lru_way)
  );

  assign dcif.ihit        = w_hit;
  assign dcif.imemload    = w_hit ? r_data[w_idx][w_hit_way][w_off] : '0;
  assign ccif.iREN[CPUID] = w_ren;
  assign ccif.iaddr[CPUID] = w_iaddr;

endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - scoreboard bench for icache_assoc (default and legacy configs)
module tb_icache_assoc;
  import cpu_types_pkg::*;

  localparam int LAT       = 10;
  localparam int MISS_LAT0 = 23;  // 1 + 2 words * (10 wait + 1 transfer)
  localparam int MISS_LAT1 = 12;  // 1 + 1 word  * (10 wait + 1 transfer)

  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;
  int   cnt0, cnt1;

  datapath_cache_if dc0 ();
  datapath_cache_if dc1 ();
  cache_control_if #(.CPUS(1)) cc0 ();
  cache_control_if #(.CPUS(1)) cc1 ();

  word_t dq0[$], aq0[$], dq1[$], aq1[$];

  icache_assoc #(.SETS(8), .WAYS(2), .BLKWORDS(2), .CPUID(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .dcif(dc0), .ccif(cc0));
  icache_assoc #(.SETS(16), .WAYS(1), .BLKWORDS(1), .CPUID(0)) dut1 (
    .CLK(CLK), .nRST(nRST), .dcif(dc1), .ccif(cc1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic word_t ram_word(word_t a);
    return (a << 8) ^ 32'hC0FF_EE00 ^ a;
  endfunction

  always @(posedge CLK) cnt0 <= (cc0.iREN[0] && cc0.iwait[0]) ? cnt0 + 1 : 0;
  always @(posedge CLK) cnt1 <= (cc1.iREN[0] && cc1.iwait[0]) ? cnt1 + 1 : 0;
  assign cc0.iwait[0] = !(cc0.iREN[0] && cnt0 == LAT);
  assign cc1.iwait[0] = !(cc1.iREN[0] && cnt1 == LAT);
  assign cc0.iload[0] = ram_word(cc0.iaddr[0]);
  assign cc1.iload[0] = ram_word(cc1.iaddr[0]);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name, logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Monitor: every hit and every memory transfer is matched against the scoreboard.
  always @(negedge CLK) begin
    if (dc0.ihit) begin
      if (dq0.size() == 0) unexpected("hit0", dc0.imemload);
      else chk("imemload0", dc0.imemload, dq0.pop_front());
    end
    if (cc0.iREN[0] && !cc0.iwait[0]) begin
      if (aq0.size() == 0) unexpected("fill0", cc0.iaddr[0]);
      else chk("iaddr0", cc0.iaddr[0], aq0.pop_front());
    end
    if (dc1.ihit) begin
      if (dq1.size() == 0) unexpected("hit1", dc1.imemload);
      else chk("imemload1", dc1.imemload, dq1.pop_front());
    end
    if (cc1.iREN[0] && !cc1.iwait[0]) begin
      if (aq1.size() == 0) unexpected("fill1", cc1.iaddr[0]);
      else chk("iaddr1", cc1.iaddr[0], aq1.pop_front());
    end
  end

  function automatic logic get_hit(int d);
    return (d == 0) ? dc0.ihit : dc1.ihit;
  endfunction

  function automatic logic get_ren(int d);
    return (d == 0) ? cc0.iREN[0] : cc1.iREN[0];
  endfunction

  task automatic fetch(int d, word_t a, bit miss);
    int cyc;
    if (d == 0) begin
      dq0.push_back(ram_word(a));
      if (miss) begin
        aq0.push_back(a & ~32'h7);
        aq0.push_back((a & ~32'h7) + 32'h4);
      end
    end else begin
      dq1.push_back(ram_word(a));
      if (miss) aq1.push_back(a & ~32'h3);
    end
    @(posedge CLK); #1;
    if (d == 0) begin dc0.imemREN = 1'b1; dc0.imemaddr = a; end
    else begin dc1.imemREN = 1'b1; dc1.imemaddr = a; end
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge CLK);
      if (get_hit(d)) break;
    end
    if (cyc == 200) unexpected("hit_timeout", a);
    else begin
      chk("latency", cyc, miss ? ((d == 0) ? MISS_LAT0 : MISS_LAT1) : 0);
      chk("iren_on_hit", {31'd0, get_ren(d)}, 32'd0);
    end
    @(posedge CLK); #1;
    if (d == 0) dc0.imemREN = 1'b0;
    else dc1.imemREN = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int i;
    vectors = 0;
    miscompares = 0;
    nRST = 1'b0;
    dc0.imemREN = 1'b0; dc0.imemaddr = '0;
    dc1.imemREN = 1'b0; dc1.imemaddr = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ihit", {31'd0, dc0.ihit}, 32'd0);
    chk("rst_imemload", dc0.imemload, 32'd0);
    chk("rst_iren", {31'd0, cc0.iREN[0]}, 32'd0);
    chk("rst_iaddr", cc0.iaddr[0], 32'd0);
    chk("rst_iren_legacy", {31'd0, cc1.iREN[0]}, 32'd0);
    nRST = 1'b1;

    fetch(0, 32'h00, 1);
    fetch(0, 32'h04, 0);
    fetch(0, 32'h40, 1);
    fetch(0, 32'h00, 0);
    fetch(0, 32'h80, 1);
    fetch(0, 32'h00, 0);
    fetch(0, 32'h40, 1);

    aq0.push_back(32'h20);
    aq0.push_back(32'h24);
    @(posedge CLK); #1;
    dc0.imemREN = 1'b1; dc0.imemaddr = 32'h20;
    repeat (3) @(posedge CLK);
    #1;
    dc0.imemREN = 1'b0; dc0.imemaddr = 32'h100;
    for (i = 0; i < 200 && aq0.size() > 0; i++) @(negedge CLK);
    chk("midfill_words_left", aq0.size(), 0);
    repeat (2) @(posedge CLK);
    fetch(0, 32'h100, 1);
    fetch(0, 32'h20, 0);
    fetch(0, 32'h24, 0);

    @(posedge CLK); #1;
    dc0.imemREN = 1'b1; dc0.imemaddr = 32'h200;
    repeat (3) @(posedge CLK);
    #1;
    chk("fill_active", {31'd0, cc0.iREN[0]}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rstfill_iren", {31'd0, cc0.iREN[0]}, 32'd0);
    chk("rstfill_iaddr", cc0.iaddr[0], 32'd0);
    chk("rstfill_imemload", dc0.imemload, 32'd0);
    @(negedge CLK);
    chk("rstfill_iren_next", {31'd0, cc0.iREN[0]}, 32'd0);
    @(posedge CLK); #1;
    dc0.imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    fetch(0, 32'h200, 1);
    fetch(0, 32'h20, 1);
    fetch(0, 32'h24, 0);

    fetch(1, 32'h00, 1);
    fetch(1, 32'h04, 1);
    fetch(1, 32'h08, 1);
    fetch(1, 32'h08, 0);

    repeat (2) @(posedge CLK);
    chk("left_dq0", dq0.size(), 0);
    chk("left_aq0", aq0.size(), 0);
    chk("left_dq1", dq1.size(), 0);
    chk("left_aq1", aq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
